// File: rtl/float2int_if.sv
// Operand-side and writeback-side handshake bundle for the float-to-integer converter.
interface float2int_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_float;
  logic [1:0]             in_rm;
  logic                   in_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [INT_W-1:0]       out_int;
  logic                   out_inexact;
  logic                   out_invalid;
  logic                   out_denormal;

  modport master (
    output in_valid, in_float, in_rm, in_signed, out_ready,
    input  in_ready, out_valid, out_int, out_inexact, out_invalid, out_denormal
  );

  modport slave (
    input  in_valid, in_float, in_rm, in_signed, out_ready,
    output in_ready, out_valid, out_int, out_inexact, out_invalid, out_denormal
  );
endinterface

// File: rtl/float2int_pipe.sv
// Three-stage float-to-integer converter: S1 classify, S2 align, S3 round/saturate into the output regs.
module float2int_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  float2int_if.slave  bus
);
  localparam int E_W  = EXP_W + 1;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int XW   = INT_W + MAN_W + 1;
  localparam int SH_W = $clog2(INT_W + 1);
  localparam logic signed [EXP_W:0] BIAS_E  = E_W'(BIAS);
  localparam logic signed [EXP_W:0] INT_W_E = E_W'(INT_W);
  localparam logic [INT_W+1:0] MAG_MAX_S = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] MAG_MIN_S = {3'b001, {(INT_W-1){1'b0}}};
  localparam logic [INT_W+1:0] MAG_MAX_U = {2'b00, {INT_W{1'b1}}};
  localparam logic [INT_W-1:0] S_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] S_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] U_MAX = {INT_W{1'b1}};

  logic v1, v2;
  logic load1, load2, load3;

  assign load3 = !bus.out_valid || bus.out_ready;
  assign load2 = !v2 || load3;
  assign load1 = !v1 || load2;
  assign bus.in_ready = load1 && !rst;

  // S1 registers
  logic             s1_sign, s1_tsigned, s1_nan, s1_inf, s1_sub, s1_zero;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_frac;
  logic [1:0]       s1_rm;

  logic exp_ones, exp_zero, frac_nz;
  assign exp_ones = &bus.in_float[MAN_W +: EXP_W];
  assign exp_zero = ~|bus.in_float[MAN_W +: EXP_W];
  assign frac_nz  = |bus.in_float[MAN_W-1:0];

  // S2 alignment
  logic signed [EXP_W:0] e;
  logic [SH_W-1:0]       sh;
  logic [XW-1:0]         x;
  logic [INT_W:0]        a_mag;
  logic                  a_guard, a_sticky, a_ovf;

  always_comb begin
    e        = $signed({1'b0, s1_exp}) - BIAS_E;
    sh       = e[SH_W-1:0];
    x        = XW'({1'b1, s1_frac}) << sh;
    a_mag    = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    a_ovf    = 1'b0;
    if (s1_nan || s1_inf || s1_sub || s1_zero) begin
      a_mag = '0;
    end else if (e > INT_W_E) begin
      a_ovf = 1'b1;
    end else if (!e[EXP_W]) begin
      a_mag    = x[MAN_W +: INT_W+1];
      a_guard  = x[MAN_W-1];
      a_sticky = |x[MAN_W-2:0];
    end else if (e == '1) begin
      // value in [0.5, 1): the hidden bit is the guard
      a_guard  = 1'b1;
      a_sticky = |s1_frac;
    end else begin
      a_sticky = 1'b1;
    end
  end

  logic           s2_sign, s2_tsigned, s2_nan, s2_inf, s2_sub, s2_zero, s2_ovf;
  logic           s2_guard, s2_sticky;
  logic [1:0]     s2_rm;
  logic [INT_W:0] s2_mag;

  // S3 round / range / negate
  logic             inexact, rnd_up, oor;
  logic [INT_W+1:0] rmag;
  logic [INT_W-1:0] r_int;
  logic             r_inx, r_inv, r_den;

  always_comb begin
    inexact = s2_guard || s2_sticky;
    case (s2_rm)
      2'b00:   rnd_up = s2_guard && (s2_sticky || s2_mag[0]);
      2'b01:   rnd_up = 1'b0;
      2'b10:   rnd_up = s2_sign && inexact;
      default: rnd_up = !s2_sign && inexact;
    endcase
    rmag  = {1'b0, s2_mag} + (INT_W+2)'(rnd_up);
    oor   = 1'b0;
    r_int = '0;
    r_inx = 1'b0;
    r_inv = 1'b0;
    r_den = 1'b0;
    if (s2_nan) begin
      r_int = s2_tsigned ? S_MAX : U_MAX;
      r_inv = 1'b1;
    end else if (s2_sub) begin
      r_den = 1'b1;
      r_inx = 1'b1;
    end else if (!s2_zero) begin
      if (s2_tsigned) oor = s2_ovf || (s2_sign ? (rmag > MAG_MIN_S) : (rmag > MAG_MAX_S));
      else            oor = s2_ovf || (s2_sign ? (rmag != '0) : (rmag > MAG_MAX_U));
      if (s2_inf || oor) begin
        r_inv = 1'b1;
        if (s2_tsigned) r_int = s2_sign ? S_MIN : S_MAX;
        else            r_int = s2_sign ? '0 : U_MAX;
      end else begin
        r_inx = inexact;
        r_int = s2_sign ? -rmag[INT_W-1:0] : rmag[INT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1               <= 1'b0;
      v2               <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_int      <= '0;
      bus.out_inexact  <= 1'b0;
      bus.out_invalid  <= 1'b0;
      bus.out_denormal <= 1'b0;
      s1_sign <= 1'b0; s1_tsigned <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0;
      s1_sub  <= 1'b0; s1_zero    <= 1'b0; s1_exp <= '0;   s1_frac <= '0; s1_rm <= '0;
      s2_sign <= 1'b0; s2_tsigned <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0;
      s2_sub  <= 1'b0; s2_zero    <= 1'b0; s2_ovf <= 1'b0; s2_guard <= 1'b0;
      s2_sticky <= 1'b0; s2_rm <= '0; s2_mag <= '0;
    end else begin
      if (load1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign    <= bus.in_float[EXP_W+MAN_W];
          s1_exp     <= bus.in_float[MAN_W +: EXP_W];
          s1_frac    <= bus.in_float[MAN_W-1:0];
          s1_rm      <= bus.in_rm;
          s1_tsigned <= bus.in_signed;
          s1_nan     <= exp_ones && frac_nz;
          s1_inf     <= exp_ones && !frac_nz;
          s1_sub     <= exp_zero && frac_nz;
          s1_zero    <= exp_zero && !frac_nz;
        end
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign    <= s1_sign;    s2_tsigned <= s1_tsigned; s2_rm   <= s1_rm;
          s2_nan     <= s1_nan;     s2_inf     <= s1_inf;     s2_sub  <= s1_sub;
          s2_zero    <= s1_zero;    s2_ovf     <= a_ovf;      s2_mag  <= a_mag;
          s2_guard   <= a_guard;    s2_sticky  <= a_sticky;
        end
      end
      if (load3) begin
        bus.out_valid <= v2;
        if (v2) begin
          bus.out_int      <= r_int;
          bus.out_inexact  <= r_inx;
          bus.out_invalid  <= r_inv;
          bus.out_denormal <= r_den;
        end
      end
    end
  end
endmodule

// File: tb/tb_float2int_pipe.sv
// Directed bench for float2int_pipe: single conversions, back-pressure stream, mid-flight reset.
module tb_float2int_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float2int_if #(.EXP_W(8), .MAN_W(23), .INT_W(32)) bus ();
  float2int_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // flags compared as {invalid, inexact, denormal}
  task automatic convert(input string tag, input logic [31:0] f, input logic [1:0] rm,
                         input logic sgn, input logic [31:0] want, input logic [2:0] wflags);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_float  = f;
    bus.in_rm     = rm;
    bus.in_signed = sgn;
    bus.out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(lat), 64'(3));
    check({tag, " int"}, 64'(bus.out_int), 64'(want));
    check({tag, " flags"}, 64'({bus.out_invalid, bus.out_inexact, bus.out_denormal}), 64'(wflags));
  endtask

  logic [31:0] flts [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
  int  p_i, p_cyc, c_cyc, got_n, ov_cnt;
  bit  saw_stall;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_float = '0; bus.in_rm = 2'b00;
    bus.in_signed = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'(0));
    check("rst out_int", 64'(bus.out_int), 64'(0));
    check("rst flags", 64'({bus.out_invalid, bus.out_inexact, bus.out_denormal}), 64'(0));
    rst = 1'b0;

    convert("5.0",        32'h40A00000, 2'b00, 1'b1, 32'd5,        3'b000);
    convert("103 rne",    32'h42CF224E, 2'b00, 1'b1, 32'd104,      3'b010);
    convert("103 rtz",    32'h42CF224E, 2'b01, 1'b1, 32'd103,      3'b010);
    convert("103 rdn",    32'h42CF224E, 2'b10, 1'b1, 32'd103,      3'b010);
    convert("103 rup",    32'h42CF224E, 2'b11, 1'b1, 32'd104,      3'b010);
    convert("2.5 rne",    32'h40200000, 2'b00, 1'b1, 32'd2,        3'b010);
    convert("3.5 rne",    32'h40600000, 2'b00, 1'b1, 32'd4,        3'b010);
    convert("-2.5 rne",   32'hC0200000, 2'b00, 1'b1, 32'hFFFFFFFE, 3'b010);
    convert("-2^31 s",    32'hCF000000, 2'b00, 1'b1, 32'h80000000, 3'b000);
    convert("2^31 s",     32'h4F000000, 2'b00, 1'b1, 32'h7FFFFFFF, 3'b100);
    convert("2^31 u",     32'h4F000000, 2'b00, 1'b0, 32'h80000000, 3'b000);
    convert("nan s",      32'h7FC00000, 2'b00, 1'b1, 32'h7FFFFFFF, 3'b100);
    convert("nan u",      32'h7FC00000, 2'b00, 1'b0, 32'hFFFFFFFF, 3'b100);
    convert("subnorm",    32'h00000001, 2'b11, 1'b1, 32'd0,        3'b011);
    convert("-0",         32'h80000000, 2'b11, 1'b1, 32'd0,        3'b000);
    convert("-0.3 u rtz", 32'hBE99999A, 2'b01, 1'b0, 32'd0,        3'b010);
    convert("-1.0 u",     32'hBF800000, 2'b00, 1'b0, 32'd0,        3'b100);
    convert("-0.3 s rdn", 32'hBE99999A, 2'b10, 1'b1, 32'hFFFFFFFF, 3'b010);
    convert("-inf s",     32'hFF800000, 2'b00, 1'b1, 32'h80000000, 3'b100);
    convert("2^32 u",     32'h4F800000, 2'b00, 1'b0, 32'hFFFFFFFF, 3'b100);
    convert("max u",      32'h4F7FFFFF, 2'b00, 1'b0, 32'hFFFFFF00, 3'b000);
    convert("2^63 s",     32'h5F000000, 2'b00, 1'b1, 32'h7FFFFFFF, 3'b100);
    convert("0.5 rne",    32'h3F000000, 2'b00, 1'b1, 32'd0,        3'b010);
    convert("0.5 rup",    32'h3F000000, 2'b11, 1'b1, 32'd1,        3'b010);
    convert("1.5 rne",    32'h3FC00000, 2'b00, 1'b1, 32'd2,        3'b010);

    // back-pressure stream
    p_i = 0; p_cyc = 0; c_cyc = 0; got_n = 0; saw_stall = 0;
    fork
      begin
        while (p_i < 6 && p_cyc < 300) begin
          @(negedge clk);
          bus.in_valid = 1'b1; bus.in_float = flts[p_i]; bus.in_rm = 2'b00; bus.in_signed = 1'b1;
          #1;
          if (bus.in_ready) p_i++;
          else saw_stall = 1;
          p_cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        while (got_n < 6 && c_cyc < 300) begin
          @(negedge clk);
          bus.out_ready = (c_cyc < 8) ? 1'b0 : 1'($urandom_range(0, 1));
          #1;
          if (bus.out_valid && bus.out_ready) begin
            check("stream int", 64'(bus.out_int), 64'(got_n + 1));
            got_n++;
          end
          c_cyc++;
        end
      end
    join
    check("stream count", 64'(got_n), 64'(6));
    check("stream stall", 64'(saw_stall), 64'(1));

    // reset with three conversions in flight
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_float = flts[i]; bus.in_rm = 2'b00; bus.in_signed = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst out_int", 64'(bus.out_int), 64'(0));
    check("midrst flags", 64'({bus.out_invalid, bus.out_inexact, bus.out_denormal}), 64'(0));
    check("midrst in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    ov_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("postrst no output", 64'(ov_cnt), 64'(0));
    convert("postrst 7.0", 32'h40E00000, 2'b00, 1'b1, 32'd7, 3'b000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
